watch_set_ctrl: RTL and testbench

Mode/set controller for the digital watch timekeeper. It sequences user button pulses through a time-set and alarm-set state machine. It pauses the timekeeper while fields are edited and commits the edited time with a one-cycle load. It also holds the alarm registers and raises a timed ring output on an alarm match.

---
 rtl/watch_set_ctrl.sv | 153 +++++++++++++++
 tb/tb_watch_set_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_set_ctrl.sv
// Mode/set controller for the watch timekeeper. It sequences time-set and alarm-set
// states, issues the one-cycle time load, and drives a timed alarm ring.
module watch_set_ctrl #(
   parameter int unsigned RING_CYCLES = 500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_alarm,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_minite,
   input  logic [5:0] cur_second,
   output logic       pause,
   output logic       load,
   output logic [4:0] load_hour,
   output logic [5:0] load_minite,
   output logic [5:0] load_second,
   output logic [2:0] mode,
   output logic [4:0] alarm_hour,
   output logic [5:0] alarm_minite,
   output logic       alarm_en,
   output logic       ring
);

   typedef enum logic [2:0] {
      S_RUN      = 3'd0,
      S_SET_HOUR = 3'd1,
      S_SET_MIN  = 3'd2,
      S_SET_SEC  = 3'd3,
      S_ALM_HOUR = 3'd4,
      S_ALM_MIN  = 3'd5
   } state_t;

   localparam logic [15:0] RING_LOAD = 16'(RING_CYCLES - 1);

   state_t      r_state;
   logic        r_pause;
   logic        r_load;
   logic [4:0]  r_load_hour;
   logic [5:0]  r_load_minite;
   logic [5:0]  r_load_second;
   logic [4:0]  r_edit_hour;
   logic [5:0]  r_edit_minite;
   logic [5:0]  r_edit_second;
   logic [4:0]  r_alarm_hour;
   logic [5:0]  r_alarm_minite;
   logic        r_alarm_en;
   logic        r_ring;
   logic [15:0] r_ring_cnt;
   logic        r_match_d;

   logic        w_match;
   logic        w_match_rise;
   logic        w_any_btn;

   function automatic logic [4:0] inc_hour(input logic [4:0] v);
      return (v == 5'd23) ? 5'd0 : v + 5'd1;
   endfunction

   function automatic logic [5:0] inc_min_sec(input logic [5:0] v);
      return (v == 6'd59) ? 6'd0 : v + 6'd1;
   endfunction

   assign w_match = (r_state == S_RUN) && r_alarm_en &&
                    (cur_hour == r_alarm_hour) && (cur_minite == r_alarm_minite) &&
                    (cur_second == 6'd0);
   assign w_match_rise = w_match && !r_match_d;
   assign w_any_btn    = btn_mode || btn_inc || btn_alarm;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_RUN;
         r_pause        <= 1'b0;
         r_load         <= 1'b0;
         r_load_hour    <= '0;
         r_load_minite  <= '0;
         r_load_second  <= '0;
         r_edit_hour    <= '0;
         r_edit_minite  <= '0;
         r_edit_second  <= '0;
         r_alarm_hour   <= '0;
         r_alarm_minite <= '0;
         r_alarm_en     <= 1'b0;
         r_ring         <= 1'b0;
         r_ring_cnt     <= '0;
         r_match_d      <= 1'b0;
      end else begin
         r_load    <= 1'b0;
         r_match_d <= w_match;
         // A ringing alarm swallows any button pulse; it only silences the ring.
         if (r_ring) begin
            if (w_any_btn || r_ring_cnt == '0) begin
               r_ring     <= 1'b0;
               r_ring_cnt <= '0;
            end else begin
               r_ring_cnt <= r_ring_cnt - 16'd1;
            end
         end else begin
            if (w_match_rise) begin
               r_ring     <= 1'b1;
               r_ring_cnt <= RING_LOAD;
            end
            if (btn_mode) begin
               unique case (r_state)
                  S_RUN: begin
                     r_state       <= S_SET_HOUR;
                     r_pause       <= 1'b1;
                     r_edit_hour   <= cur_hour;
                     r_edit_minite <= cur_minite;
                     r_edit_second <= cur_second;
                  end
                  S_SET_HOUR: r_state <= S_SET_MIN;
                  S_SET_MIN:  r_state <= S_SET_SEC;
                  S_SET_SEC: begin
                     r_state       <= S_ALM_HOUR;
                     r_pause       <= 1'b0;
                     r_load        <= 1'b1;
                     r_load_hour   <= r_edit_hour;
                     r_load_minite <= r_edit_minite;
                     r_load_second <= r_edit_second;
                  end
                  S_ALM_HOUR: r_state <= S_ALM_MIN;
                  default:    r_state <= S_RUN;
               endcase
            end else if (btn_inc) begin
               unique case (r_state)
                  S_SET_HOUR: r_edit_hour    <= inc_hour(r_edit_hour);
                  S_SET_MIN:  r_edit_minite  <= inc_min_sec(r_edit_minite);
                  S_SET_SEC:  r_edit_second  <= inc_min_sec(r_edit_second);
                  S_ALM_HOUR: r_alarm_hour   <= inc_hour(r_alarm_hour);
                  S_ALM_MIN:  r_alarm_minite <= inc_min_sec(r_alarm_minite);
                  default:    ;
               endcase
            end
            if (btn_alarm && r_state == S_RUN)
               r_alarm_en <= !r_alarm_en;
         end
      end
   end

   assign pause        = r_pause;
   assign load         = r_load;
   assign load_hour    = r_load_hour;
   assign load_minite  = r_load_minite;
   assign load_second  = r_load_second;
   assign mode         = r_state;
   assign alarm_hour   = r_alarm_hour;
   assign alarm_minite = r_alarm_minite;
   assign alarm_en     = r_alarm_en;
   assign ring         = r_ring;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed bench for watch_set_ctrl: set sequence, load pulse, alarm set, ring timing
// and silencing, with hand-computed expectations.
module tb_watch_set_ctrl;

   logic       clk;
   logic       reset;
   logic       btn_mode;
   logic       btn_inc;
   logic       btn_alarm;
   logic [4:0] cur_hour;
   logic [5:0] cur_minite;
   logic [5:0] cur_second;
   logic       pause;
   logic       load;
   logic [4:0] load_hour;
   logic [5:0] load_minite;
   logic [5:0] load_second;
   logic [2:0] mode;
   logic [4:0] alarm_hour;
   logic [5:0] alarm_minite;
   logic       alarm_en;
   logic       ring;

   int n_cmp  = 0;
   int n_fail = 0;

   watch_set_ctrl #(.RING_CYCLES(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_mode     (btn_mode),
      .btn_inc      (btn_inc),
      .btn_alarm    (btn_alarm),
      .cur_hour     (cur_hour),
      .cur_minite   (cur_minite),
      .cur_second   (cur_second),
      .pause        (pause),
      .load         (load),
      .load_hour    (load_hour),
      .load_minite  (load_minite),
      .load_second  (load_second),
      .mode         (mode),
      .alarm_hour   (alarm_hour),
      .alarm_minite (alarm_minite),
      .alarm_en     (alarm_en),
      .ring         (ring)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic m, input logic i, input logic a);
      btn_mode  = m;
      btn_inc   = i;
      btn_alarm = a;
      tick();
      btn_mode  = 1'b0;
      btn_inc   = 1'b0;
      btn_alarm = 1'b0;
   endtask

   task automatic incs(input int n);
      for (int k = 0; k < n; k++) pulse(1'b0, 1'b1, 1'b0);
   endtask

   task automatic set_cur(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
      cur_hour   = h;
      cur_minite = m;
      cur_second = s;
   endtask

   initial begin
      reset     = 1'b1;
      btn_mode  = 1'b0;
      btn_inc   = 1'b0;
      btn_alarm = 1'b0;
      set_cur(5'd0, 6'd0, 6'd0);
      tick();
      tick();
      check("rst_mode",     32'(mode), 0);
      check("rst_pause",    32'(pause), 0);
      check("rst_load",     32'(load), 0);
      check("rst_ring",     32'(ring), 0);
      check("rst_alarm_en", 32'(alarm_en), 0);
      check("rst_alm_hour", 32'(alarm_hour), 0);
      check("rst_alm_min",  32'(alarm_minite), 0);
      check("rst_load_hr",  32'(load_hour), 0);
      reset = 1'b0;
      tick();

      // Reset in the middle of SET_MIN with edit minute 30.
      set_cur(5'd1, 6'd30, 6'd0);
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      check("midset_mode",  32'(mode), 2);
      check("midset_pause", 32'(pause), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst2_mode",  32'(mode), 0);
      check("rst2_pause", 32'(pause), 0);
      check("rst2_load",  32'(load), 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("rst2_noload", 32'(load), 0);
         check("rst2_hold",   32'(mode), 0);
      end

      // Full set sequence from 10:20:05.
      set_cur(5'd10, 6'd20, 6'd5);
      pulse(1'b1, 1'b0, 1'b0);
      check("sh_mode",  32'(mode), 1);
      check("sh_pause", 32'(pause), 1);
      incs(15);
      check("sh_hold", 32'(mode), 1);
      pulse(1'b1, 1'b0, 1'b0);
      check("sm_mode",  32'(mode), 2);
      check("sm_pause", 32'(pause), 1);
      incs(40);
      pulse(1'b1, 1'b0, 1'b0);
      check("ss_mode",  32'(mode), 3);
      check("ss_pause", 32'(pause), 1);
      check("ss_noload", 32'(load), 0);
      incs(2);
      pulse(1'b1, 1'b0, 1'b0);
      check("ld_mode",  32'(mode), 4);
      check("ld_pause", 32'(pause), 0);
      check("ld_load",  32'(load), 1);
      check("ld_hour",  32'(load_hour), 1);
      check("ld_min",   32'(load_minite), 0);
      check("ld_sec",   32'(load_second), 7);
      tick();
      check("ld_once",  32'(load), 0);

      // Alarm set to 06:30 through the ALM states.
      incs(6);
      check("ah_val",   32'(alarm_hour), 6);
      check("ah_pause", 32'(pause), 0);
      pulse(1'b1, 1'b0, 1'b0);
      check("am_mode",  32'(mode), 5);
      incs(30);
      check("am_val",   32'(alarm_minite), 30);
      pulse(1'b1, 1'b0, 1'b0);
      check("run_mode", 32'(mode), 0);
      check("run_alm_en", 32'(alarm_en), 0);

      // btn_alarm outside RUN is ignored; mode beats inc in SET_HOUR.
      set_cur(5'd5, 6'd0, 6'd0);
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b0, 1'b1);
      check("sh_alm_ign", 32'(alarm_en), 0);
      check("sh_alm_mode", 32'(mode), 1);
      pulse(1'b1, 1'b1, 1'b0);
      check("both_mode", 32'(mode), 2);
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      check("both_load", 32'(load), 1);
      check("both_hour", 32'(load_hour), 5);
      check("both_min",  32'(load_minite), 0);
      check("both_sec",  32'(load_second), 0);
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      check("both_run", 32'(mode), 0);
      check("both_alm_hr", 32'(alarm_hour), 6);

      // Matching time with alarm disarmed.
      set_cur(5'd6, 6'd30, 6'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("dis_ring", 32'(ring), 0);
      end
      set_cur(5'd6, 6'd30, 6'd1);
      pulse(1'b0, 1'b0, 1'b1);
      check("arm", 32'(alarm_en), 1);

      // Match: ring one cycle later, exactly 8 cycles, no retrigger.
      set_cur(5'd6, 6'd30, 6'd0);
      tick();
      check("ring_rise", 32'(ring), 1);
      for (int k = 0; k < 7; k++) begin
         tick();
         check("ring_hold", 32'(ring), 1);
      end
      tick();
      check("ring_end", 32'(ring), 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("ring_noretrig", 32'(ring), 0);
      end

      // Silence with btn_inc.
      set_cur(5'd6, 6'd30, 6'd1);
      tick();
      set_cur(5'd6, 6'd30, 6'd0);
      tick();
      check("inc_rise", 32'(ring), 1);
      pulse(1'b0, 1'b1, 1'b0);
      check("inc_silence", 32'(ring), 0);
      tick();
      check("inc_stay", 32'(ring), 0);

      // Silence with btn_alarm: alarm_en must not toggle.
      set_cur(5'd6, 6'd30, 6'd1);
      tick();
      set_cur(5'd6, 6'd30, 6'd0);
      tick();
      check("alm_rise", 32'(ring), 1);
      pulse(1'b0, 1'b0, 1'b1);
      check("alm_silence", 32'(ring), 0);
      check("alm_en_kept", 32'(alarm_en), 1);

      // Silence with btn_mode: pulse consumed, mode stays RUN.
      set_cur(5'd6, 6'd30, 6'd1);
      tick();
      set_cur(5'd6, 6'd30, 6'd0);
      tick();
      check("mode_rise", 32'(ring), 1);
      pulse(1'b1, 1'b0, 1'b0);
      check("mode_silence", 32'(ring), 0);
      check("mode_consumed", 32'(mode), 0);
      check("mode_nopause", 32'(pause), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
